// File: rtl/hist_drain.sv
// hist_drain: scans every histogram bin once, streams (bin, count) pairs over valid/ready
// and optionally zeroes each bin as its data returns. hold_upd stalls the updater meanwhile.
module hist_drain #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear_en,
  output logic              busy,
  output logic              hold_upd,
  output logic              done,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_bin,
  output logic [DATA_W-1:0] out_count,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_BIN = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_BIN  = ADDR_W'(1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_clr;
  logic              r_rd_vld;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ret_bin;
  logic              r_h_v;
  logic              r_t_v;
  logic [ADDR_W-1:0] r_h_bin;
  logic [ADDR_W-1:0] r_t_bin;
  logic [DATA_W-1:0] r_h_cnt;
  logic [DATA_W-1:0] r_t_cnt;

  logic              w_pop;
  logic              w_push;
  logic              w_rd_en;
  logic [1:0]        w_level;

  // Slots committed after this cycle: FIFO entries plus the returning beat, less the one
  // leaving now. A new read is safe only if that leaves room for its data.
  always_comb begin
    w_pop   = r_h_v & out_ready;
    w_push  = r_rd_vld;
    w_level = {1'b0, r_h_v} + {1'b0, r_t_v} + {1'b0, r_rd_vld} - {1'b0, w_pop};
    w_rd_en = (r_state == S_SCAN) && (w_level < 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_clr     <= 1'b0;
      r_addr    <= '0;
      r_rd_vld  <= 1'b0;
      r_ret_bin <= '0;
      r_wr_en   <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_wr_en  <= w_rd_en & r_clr;
      if (w_rd_en) begin
        r_ret_bin <= r_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SCAN;
            r_busy  <= 1'b1;
            r_clr   <= clear_en;
            r_addr  <= '0;
          end
        end
        S_SCAN: begin
          if (w_rd_en) begin
            if (r_addr == LAST_BIN) begin
              r_state <= S_FLUSH;
            end else begin
              r_addr <= r_addr + ONE_BIN;
            end
          end
        end
        S_FLUSH: begin
          if (w_level == 2'd0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_clr   <= 1'b0;
          r_addr  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Two-entry output FIFO; the head register drives the stream directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_v   <= 1'b0;
      r_t_v   <= 1'b0;
      r_h_bin <= '0;
      r_t_bin <= '0;
      r_h_cnt <= '0;
      r_t_cnt <= '0;
    end else if (w_pop) begin
      if (r_t_v) begin
        r_h_bin <= r_t_bin;
        r_h_cnt <= r_t_cnt;
        r_t_v   <= w_push;
        if (w_push) begin
          r_t_bin <= r_ret_bin;
          r_t_cnt <= ram_rd_data;
        end
      end else begin
        r_h_v <= w_push;
        if (w_push) begin
          r_h_bin <= r_ret_bin;
          r_h_cnt <= ram_rd_data;
        end
      end
    end else if (w_push) begin
      if (!r_h_v) begin
        r_h_v   <= 1'b1;
        r_h_bin <= r_ret_bin;
        r_h_cnt <= ram_rd_data;
      end else begin
        r_t_v   <= 1'b1;
        r_t_bin <= r_ret_bin;
        r_t_cnt <= ram_rd_data;
      end
    end
  end

  assign busy        = r_busy;
  assign hold_upd    = r_busy;
  assign done        = r_done;
  assign ram_rd_en   = w_rd_en;
  assign ram_rd_addr = r_addr;
  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_ret_bin;
  assign ram_wr_data = '0;
  assign out_valid   = r_h_v;
  assign out_bin     = r_h_bin;
  assign out_count   = r_h_cnt;
  assign out_last    = r_h_v & (r_h_bin == LAST_BIN);

endmodule

// File: tb/tb_hist_drain.sv
// Bench for hist_drain: behavioural RAM, expected-beat queue filled at start, table of scan
// scenarios plus hand-written stall and mid-scan reset sequences.
module tb_hist_drain;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NB     = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              clear_en = 1'b0;
  logic              out_ready = 1'b1;
  logic              busy, hold_upd, done, ram_rd_en, ram_wr_en, out_valid, out_last;
  logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr, out_bin;
  logic [DATA_W-1:0] ram_rd_data = '0;
  logic [DATA_W-1:0] ram_wr_data, out_count;

  hist_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_en(clear_en),
    .busy(busy), .hold_upd(hold_upd), .done(done),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_count(out_count), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              bin;
    logic [DATA_W-1:0] cnt;
    logic            last;
  } beat_t;

  typedef struct {
    bit clr;
    int rdy;
    bit preload;
    int offs;
    bit restart;
    bit toggle;
    int exp_wr;
    int exp_done;
  } vec_t;

  logic [DATA_W-1:0] mem [NB];
  logic [DATA_W-1:0] exp_mem [NB];
  beat_t q[$];
  beat_t mon_e;
  vec_t  vecs[7];

  int n_checks = 0;
  int n_err = 0;
  int tick = 0;
  int t0 = 0;
  int rel;
  int rdy_mode = 0;
  bit mon_en = 1'b0;
  int rd_cnt, wr_cnt, beats, done_cnt, done_rel, busy_on, busy_off;
  int rd_cyc[NB];
  int wr_cyc[NB];
  int beat_cyc[NB];
  bit prev_stall;
  logic [ADDR_W-1:0] p_bin;
  logic [DATA_W-1:0] p_cnt;
  logic              p_last;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // RAM model: 1-cycle read latency, write port used for clears.
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end

  always @(posedge clk) tick <= tick + 1;

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 3);
      2: out_ready = !(((tick - t0) >= 3) && ((tick - t0) <= 12));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: scoreboard pops, stall stability, read/write bookkeeping.
  always @(negedge clk) begin
    if (mon_en) begin
      rel = tick - t0;
      chk("hold_upd_eq_busy", int'(hold_upd), int'(busy));
      if (busy && busy_on < 0) busy_on = rel;
      if (!busy && busy_on >= 0 && busy_off < 0) busy_off = rel;
      if (ram_rd_en) begin
        chk("rd_addr_seq", int'(ram_rd_addr), rd_cnt);
        if (rd_cnt < NB) rd_cyc[rd_cnt] = rel;
        rd_cnt++;
      end
      if (ram_wr_en) begin
        chk("wr_data_zero", int'(ram_wr_data), 0);
        wr_cyc[ram_wr_addr] = rel;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_bin", int'(out_bin), int'(p_bin));
        chk("stall_count", int'(out_count), int'(p_cnt));
        chk("stall_last", int'(out_last), int'(p_last));
      end
      if (out_valid && out_ready) begin
        beats++;
        if (q.size() == 0) begin
          fail_now("extra_beat");
        end else begin
          mon_e = q.pop_front();
          chk("beat_bin", int'(out_bin), mon_e.bin);
          chk("beat_count", int'(out_count), int'(mon_e.cnt));
          chk("beat_last", int'(out_last), int'(mon_e.last));
          if (mon_e.bin < NB) beat_cyc[mon_e.bin] = rel;
        end
      end
      chk("outstanding_le2", int'((rd_cnt - beats) <= 2), 1);
      prev_stall = out_valid && !out_ready;
      p_bin  = out_bin;
      p_cnt  = out_count;
      p_last = out_last;
    end
  end

  task automatic reset_mon();
    rd_cnt = 0; wr_cnt = 0; beats = 0; done_cnt = 0; done_rel = -1;
    busy_on = -1; busy_off = -1; prev_stall = 1'b0;
    for (int k = 0; k < NB; k++) begin
      rd_cyc[k] = -1; wr_cyc[k] = -1; beat_cyc[k] = -1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_hold_upd"}, int'(hold_upd), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rd_en"}, int'(ram_rd_en), 0);
    chk({tag, "_wr_en"}, int'(ram_wr_en), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_rd_addr"}, int'(ram_rd_addr), 0);
    chk({tag, "_wr_addr"}, int'(ram_wr_addr), 0);
    chk({tag, "_out_bin"}, int'(out_bin), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
    chk({tag, "_wr_data"}, int'(ram_wr_data), 0);
  endtask

  task automatic run_scan(input vec_t v);
    beat_t b;
    if (v.preload) begin
      for (int k = 0; k < NB; k++) begin
        exp_mem[k] = DATA_W'(3 * k + v.offs);
        mem[k] = exp_mem[k];
      end
    end
    reset_mon();
    q.delete();
    clear_en = v.clr;
    rdy_mode = v.rdy;
    @(posedge clk);
    #1;
    t0 = tick;
    start = 1'b1;
    for (int k = 0; k < NB; k++) begin
      b.bin = k;
      b.cnt = exp_mem[k];
      b.last = (k == NB - 1);
      q.push_back(b);
      if (v.clr) exp_mem[k] = '0;
    end
    mon_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      start = v.restart && ((tick - t0) == 10);
      if (v.toggle && (tick - t0) == 12) clear_en = ~clear_en;
      if (done_cnt > 0 && (tick - t0) > done_rel + 2) break;
    end
    mon_en = 1'b0;
    start = 1'b0;
    clear_en = 1'b0;
    rdy_mode = 0;
    chk("done_pulses", done_cnt, 1);
    chk("beats", beats, NB);
    chk("queue_left", q.size(), 0);
    chk("reads", rd_cnt, NB);
    chk("writes", wr_cnt, v.exp_wr);
    chk("busy_on_cycle", busy_on, 1);
    chk("busy_off_after_done", busy_off, done_rel + 1);
    if (v.exp_done >= 0) begin
      chk("done_cycle", done_rel, v.exp_done);
      for (int k = 0; k < NB; k++) begin
        chk("rd_cycle", rd_cyc[k], 1 + k);
        chk("beat_cycle", beat_cyc[k], 3 + k);
      end
    end
    if (v.exp_wr == NB) begin
      for (int k = 0; k < NB; k++) chk("clear_cycle", wr_cyc[k], rd_cyc[k] + 1);
    end
    for (int k = 0; k < NB; k++) chk("ram_content", int'(mem[k]), int'(exp_mem[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{clr: 1'b0, rdy: 0, preload: 1'b1, offs: 0,  restart: 1'b0, toggle: 1'b0, exp_wr: 0,  exp_done: 35};
    vecs[1] = '{clr: 1'b1, rdy: 0, preload: 1'b1, offs: 0,  restart: 1'b0, toggle: 1'b0, exp_wr: NB, exp_done: 35};
    vecs[2] = '{clr: 1'b0, rdy: 0, preload: 1'b0, offs: 0,  restart: 1'b0, toggle: 1'b0, exp_wr: 0,  exp_done: 35};
    vecs[3] = '{clr: 1'b0, rdy: 1, preload: 1'b1, offs: 7,  restart: 1'b0, toggle: 1'b0, exp_wr: 0,  exp_done: -1};
    vecs[4] = '{clr: 1'b1, rdy: 1, preload: 1'b1, offs: 11, restart: 1'b0, toggle: 1'b0, exp_wr: NB, exp_done: -1};
    vecs[5] = '{clr: 1'b0, rdy: 0, preload: 1'b1, offs: 5,  restart: 1'b1, toggle: 1'b1, exp_wr: 0,  exp_done: 35};
    vecs[6] = '{clr: 1'b1, rdy: 0, preload: 1'b1, offs: 9,  restart: 1'b1, toggle: 1'b1, exp_wr: NB, exp_done: 35};
    for (int k = 0; k < NB; k++) begin
      mem[k] = '0;
      exp_mem[k] = '0;
    end

    #3;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_scan(vecs[i]);

    // Downstream stalled for cycles 3..12: only bins 0 and 1 may be read meanwhile.
    run_scan('{clr: 1'b0, rdy: 2, preload: 1'b1, offs: 1, restart: 1'b0, toggle: 1'b0, exp_wr: 0, exp_done: -1});
    chk("stall_rd1_cycle", rd_cyc[1], 2);
    chk("stall_no_read_during", int'(rd_cyc[2] >= 13), 1);
    chk("stall_bin0_xfer", beat_cyc[0], 13);
    chk("stall_bin1_xfer", beat_cyc[1], 14);

    // Reset in cycle 12 of a clearing scan: bins 0..9 are already zeroed.
    for (int k = 0; k < NB; k++) begin
      exp_mem[k] = DATA_W'(3 * k + 2);
      mem[k] = exp_mem[k];
    end
    clear_en = 1'b1;
    @(posedge clk);
    #1;
    t0 = tick;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 0; c < 20 && (tick - t0) < 12; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    for (int k = 0; k < 10; k++) exp_mem[k] = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    clear_en = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_reset_done", int'(done), 0);
      chk("post_reset_busy", int'(busy), 0);
    end
    run_scan('{clr: 1'b0, rdy: 0, preload: 1'b0, offs: 0, restart: 1'b0, toggle: 1'b0, exp_wr: 0, exp_done: 35});

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
